multpath_arbiter: RTL
=====================

// Module: multpath_arbiter
// PURPOSE
//  Shares one multicycle-path adder (operand regs -> combinational add -> sum capture)
//  between two requesters. Arbitrates, loads operand registers, waits MCP_CYCLES for
//  the multicycle path to settle, captures the sum, returns it tagged with requester id.
//  Sits between client logic and the shared adder; single clock domain.
// PARAMETERS
//  IN_W        4          operand width
//  SUM_W       IN_W+1     sum width (full carry kept, no overflow possible)
//  MCP_CYCLES  2          cycles from operand load to sum capture; legal range 1..15
// PORTS
//  clock       in   1      single clock, all flops posedge
//  reset       in   1      synchronous, active-high
//  req0_valid  in   1      requester 0 has an operation
//  req0_a      in   IN_W   requester 0 operand A
//  req0_b      in   IN_W   requester 0 operand B
//  req0_ready  out  1      requester 0 operation accepted this cycle
//  req1_valid  in   1      requester 1 has an operation
//  req1_a      in   IN_W   requester 1 operand A
//  req1_b      in   IN_W   requester 1 operand B
//  req1_ready  out  1      requester 1 operation accepted this cycle
//  op_a        out  IN_W   registered operand A to shared adder
//  op_b        out  IN_W   registered operand B to shared adder
//  add_sum     in   SUM_W  combinational sum from shared adder (multicycle path)
//  rsp_valid   out  1      result available
//  rsp_id      out  1      requester that owns rsp_sum
//  rsp_sum     out  SUM_W  captured sum
//  rsp_ready   in   1      consumer takes result
//  busy        out  1      high in any state except IDLE
// BEHAVIOUR
//  - Reset (sync): state=IDLE, op_a=op_b=0, rsp_valid=0, rsp_id=0, rsp_sum=0, cnt=0,
//    last_grant=1 (requester 0 wins first tie). Reset mid-operation drops the op; no rsp.
//  - Handshake: transfer on valid&&ready. reqN_ready is combinational: high only in IDLE
//    for the granted requester; at most one ready high per cycle. Requester holds
//    valid/operands stable until ready; arbiter never revokes a grant in the same cycle.
//  - Arbitration (IDLE): one valid -> grant it. Both valid -> grant the one != last_grant.
//    last_grant updates on accept.
//  - FSM: IDLE --accept--> SETTLE: op_a/op_b load on accept edge, cnt=MCP_CYCLES-1.
//    SETTLE: op_a/op_b held constant; cnt decrements each cycle; when cnt==0 at a clock
//    edge, rsp_sum<=add_sum, rsp_id<=owner, rsp_valid<=1, state->RESP.
//    RESP: outputs held; rsp_valid&&rsp_ready -> rsp_valid<=0, state->IDLE.
//  - Latency: accept edge T -> rsp_valid high after edge T+MCP_CYCLES.
//    Throughput: next accept no earlier than cycle after response taken.
//  - rsp_ready while rsp_valid=0 is ignored. reqN_valid in SETTLE/RESP is ignored (ready=0).
//  - op_a/op_b never change outside an accept edge, guaranteeing the multicycle constraint.
// CONFIGURATION
//  MULTPATH_PRIO_EN defined: fixed priority, requester 0 always wins when both valid;
//   last_grant unused. Undefined (default): round-robin as above.
// TESTING
//  1 reset; req0 a=3 b=4 alone -> req0_ready same cycle; rsp_valid after 2 edges, sum=7 id=0
//  2 both valid (0: 15+15, 1: 1+2), rsp_ready=1 -> rsp 30 id=0, then 3 id=1 (RR default)
//  3 both valid continuously, MULTPATH_PRIO_EN set -> req0 granted every time, req1 starved
//  4 rsp_ready=0 for 5 cycles in RESP -> rsp_valid/sum/id stable, no ready, busy=1
//  5 reset asserted in SETTLE -> next cycle IDLE, op_a=op_b=0, rsp_valid never rises
//  6 MCP_CYCLES=1 and 4: op_a/op_b stable whole window; rsp_valid exactly N edges after accept

Source files
------------

// File: rtl/multpath_arbiter.sv
// Two-requester front end for a shared multicycle-path adder.
// Define MULTPATH_PRIO_EN for fixed priority to requester 0; default is round-robin.
module multpath_arbiter #(
  parameter int unsigned IN_W       = 4,
  parameter int unsigned SUM_W      = IN_W + 1,
  parameter int unsigned MCP_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [IN_W-1:0]  req0_a,
  input  logic [IN_W-1:0]  req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [IN_W-1:0]  req1_a,
  input  logic [IN_W-1:0]  req1_b,
  output logic             req1_ready,
  output logic [IN_W-1:0]  op_a,
  output logic [IN_W-1:0]  op_b,
  input  logic [SUM_W-1:0] add_sum,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [SUM_W-1:0] rsp_sum,
  input  logic             rsp_ready,
  output logic             busy
);

  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            owner_q;
  logic            grant_any;
  logic            grant_id;
`ifndef MULTPATH_PRIO_EN
  logic            last_grant_q;
`endif

  always_comb begin
    grant_any = (state_q == StIdle) && (req0_valid || req1_valid);
    grant_id  = req1_valid;
    if (req0_valid && req1_valid) begin
`ifdef MULTPATH_PRIO_EN
      grant_id = 1'b0;
`else
      grant_id = ~last_grant_q;
`endif
    end
  end

  assign req0_ready = grant_any && !grant_id;
  assign req1_ready = grant_any && grant_id;
  assign busy       = (state_q != StIdle);

  // Operand registers only move on an accept edge, which is what makes the adder
  // path a legal multicycle path.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      op_a         <= '0;
      op_b         <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_sum      <= '0;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
`ifndef MULTPATH_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_any) begin
            op_a         <= grant_id ? req1_a : req0_a;
            op_b         <= grant_id ? req1_b : req0_b;
            owner_q      <= grant_id;
`ifndef MULTPATH_PRIO_EN
            last_grant_q <= grant_id;
`endif
            cnt_q        <= CntW'(MCP_CYCLES - 1);
            state_q      <= StSettle;
          end
        end
        StSettle: begin
          if (cnt_q == '0) begin
            rsp_sum   <= add_sum;
            rsp_id    <= owner_q;
            rsp_valid <= 1'b1;
            state_q   <= StResp;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
